// File: rtl/case_4_mul_share_arb.sv
// One shared signed multiplier serving NREQ valid/ready requesters through a round-robin
// arbiter, with results queued in a small tagged FIFO and returned on a single response port.
module case_4_mul_share_arb #(
  parameter int NREQ   = 4,
  parameter int DIN0_W = 8,
  parameter int DIN1_W = 5,
  parameter int DOUT_W = 8,
  parameter int DEPTH  = 2,
  parameter int IDW    = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIN0_W-1:0]   req_a,
  input  logic [NREQ*DIN1_W-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [DOUT_W-1:0]        rsp_data,
  output logic [15:0]              stat_ops
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = IDW + DOUT_W;

  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  rd_ptr_inc;
  logic [PW-1:0]  wr_ptr_inc;
  logic [IDW-1:0] ptr;
  logic [EW-1:0]  mem [DEPTH];

  logic           can_push;
  logic           gnt_any;
  logic [IDW-1:0] gnt;
  logic           xfer;
  logic           pop;
  logic           head_from_push;

  logic signed [DIN0_W-1:0]        a_sel;
  logic signed [DIN1_W-1:0]        b_sel;
  logic signed [DIN0_W+DIN1_W-1:0] prod;
  logic [EW-1:0]                   push_word;

  // Scan from ptr upward; iterating in reverse leaves the first hit in the scan order.
  always_comb begin
    int idx;
    idx      = 0;
    can_push = (count < CW'(DEPTH)) && ap_rst_n;
    gnt_any  = 1'b0;
    gnt      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt     = IDW'(idx);
      end
    end
    req_ready = '0;
    if (can_push && gnt_any) req_ready[gnt] = 1'b1;
  end

  assign xfer = can_push && gnt_any;
  assign pop  = rsp_valid && rsp_ready;

  assign a_sel     = req_a[int'(gnt)*DIN0_W +: DIN0_W];
  assign b_sel     = req_b[int'(gnt)*DIN1_W +: DIN1_W];
  assign prod      = a_sel * b_sel;
  assign push_word = {gnt, prod[DOUT_W-1:0]};

  assign rd_ptr_inc = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  assign wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

  always_comb begin
    count_next = count;
    if (xfer && !pop)      count_next = count + 1'b1;
    else if (!xfer && pop) count_next = count - 1'b1;
  end

  // The pushed entry becomes the head when the FIFO is (or is about to be) empty.
  assign head_from_push = xfer && ((count == '0) || ((count == CW'(1)) && pop));

  always_ff @(posedge ap_clk) begin
    if (xfer) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      stat_ops  <= '0;
    end else begin
      count     <= count_next;
      rsp_valid <= (count_next != '0);
      if (xfer) begin
        wr_ptr <= wr_ptr_inc;
        ptr    <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr_inc;
        stat_ops <= stat_ops + 16'd1;
      end
      if (head_from_push) begin
        {rsp_id, rsp_data} <= push_word;
      end else if (pop && (count > CW'(1))) begin
        {rsp_id, rsp_data} <= mem[rd_ptr_inc];
      end
    end
  end

endmodule
